// File: rtl/col_vec_gen.sv
// col_vec_gen: turns a raster pixel stream into KERNEL_H-tall column vectors
// for a downstream column PE. Previous rows are held in line buffers indexed
// by column. Element 0 of o_data is the oldest (top) row.
// Optional build macro COL_VEC_GEN_ZERO_PAD_EN: emit a vector for every pixel,
// with rows above the top image edge forced to zero.
module col_vec_gen #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned KERNEL_H = 7,
    parameter int unsigned IMG_W    = 64
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_vld,
    input  logic                             i_eof,
    input  logic [DATA_W-1:0]                i_data,
    output logic                             o_rdy,
    input  logic                             i_rdy,
    output logic                             o_vld,
    output logic                             o_eof,
    output logic [KERNEL_H-1:0][DATA_W-1:0]  o_data
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(KERNEL_H);
    localparam int unsigned LB_N  = KERNEL_H - 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(KERNEL_H - 1);
    localparam logic [ROW_W-1:0] ROW_PRE  = ROW_W'(KERNEL_H - 2);

    typedef enum logic {
        PRIME  = 1'b0,
        STREAM = 1'b1
    } state_e;

    state_e                            state_q, state_d;
    logic [COL_W-1:0]                  col_q, col_d;
    logic [ROW_W-1:0]                  row_q, row_d;
    logic                              o_vld_q, o_vld_d;
    logic                              o_eof_q, o_eof_d;
    logic [KERNEL_H-1:0][DATA_W-1:0]   o_data_q, o_data_d;

    // Line buffers are plain storage: never reset, only read at the live column.
    logic [DATA_W-1:0]                 lb_mem [LB_N][IMG_W];
    logic [DATA_W-1:0]                 lb_rd  [LB_N];

    logic                              accept;
    logic                              produce;

    assign o_rdy  = !o_vld_q || i_rdy;
    assign accept = i_vld && o_rdy;

`ifdef COL_VEC_GEN_ZERO_PAD_EN
    assign produce = accept;
`else
    assign produce = accept && (state_q == STREAM);
`endif

    assign o_vld  = o_vld_q;
    assign o_eof  = o_eof_q;
    assign o_data = o_data_q;

    // Read every line buffer at the current column.
    always_comb begin
        for (int unsigned k = 0; k < LB_N; k++) begin
            lb_rd[k] = lb_mem[k][col_q];
        end
    end

    // Next-state: output handshake, vector assembly, column/row counters, FSM.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        o_vld_d  = o_vld_q;
        o_eof_d  = o_eof_q;
        o_data_d = o_data_q;

        if (produce) begin
            o_data_d[KERNEL_H-1] = i_data;
            for (int unsigned k = 0; k < LB_N; k++) begin
                o_data_d[k] = lb_rd[k];
`ifdef COL_VEC_GEN_ZERO_PAD_EN
                // Rows that lie above the top image edge read as zero.
                if (k + 32'(row_q) < KERNEL_H - 1) begin
                    o_data_d[k] = '0;
                end
`endif
            end
        end

        if (accept) begin
            o_vld_d = produce;
            o_eof_d = produce && i_eof;
        end else if (o_vld_q && i_rdy) begin
            o_vld_d = 1'b0;
            o_eof_d = 1'b0;
        end

        if (accept) begin
            if (i_eof) begin
                col_d   = '0;
                row_d   = '0;
                state_d = PRIME;
            end else if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q != ROW_LAST) begin
                    row_d = row_q + ROW_W'(1);
                end
                if (state_q == PRIME && row_q == ROW_PRE) begin
                    state_d = STREAM;
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= PRIME;
            col_q    <= '0;
            row_q    <= '0;
            o_vld_q  <= 1'b0;
            o_eof_q  <= 1'b0;
            o_data_q <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            o_vld_q  <= o_vld_d;
            o_eof_q  <= o_eof_d;
            o_data_q <= o_data_d;
        end
    end

    // Shift the column one row older and store the new pixel as the newest row.
    always_ff @(posedge i_clk) begin
        if (!i_rst && accept) begin
            for (int unsigned k = 0; k + 1 < LB_N; k++) begin
                lb_mem[k][col_q] <= lb_rd[k+1];
            end
            lb_mem[LB_N-1][col_q] <= i_data;
        end
    end

endmodule

// File: tb/tb_col_vec_gen.sv
// Directed bench for col_vec_gen with KERNEL_H=3, IMG_W=4, pixel = row*16+col.
module tb_col_vec_gen;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned KERNEL_H = 3;
    localparam int unsigned IMG_W    = 4;

    logic                            clk;
    logic                            i_rst;
    logic                            i_vld;
    logic                            i_eof;
    logic [DATA_W-1:0]               i_data;
    logic                            o_rdy;
    logic                            i_rdy;
    logic                            o_vld;
    logic                            o_eof;
    logic [KERNEL_H-1:0][DATA_W-1:0] o_data;

    int n_vec;
    int n_err;

    col_vec_gen #(
        .DATA_W   (DATA_W),
        .KERNEL_H (KERNEL_H),
        .IMG_W    (IMG_W)
    ) dut (
        .i_clk  (clk),
        .i_rst  (i_rst),
        .i_vld  (i_vld),
        .i_eof  (i_eof),
        .i_data (i_data),
        .o_rdy  (o_rdy),
        .i_rdy  (i_rdy),
        .o_vld  (o_vld),
        .o_eof  (o_eof),
        .o_data (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected column vector, given oldest (top) to newest element.
    function automatic logic [23:0] vec(input logic [7:0] e0, input logic [7:0] e1,
                                        input logic [7:0] e2);
        return {e2, e1, e0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        i_rst  = 1'b1;
        i_vld  = 1'b0;
        i_eof  = 1'b0;
        i_data = '0;
        i_rdy  = 1'b0;

        // Reset for two cycles.
        tick();
        tick();
        chk("rst_vld",  32'(o_vld),  32'd0);
        chk("rst_eof",  32'(o_eof),  32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        i_rst = 1'b0;
        tick();
        chk("rst_rdy", 32'(o_rdy), 32'd1);

`ifdef COL_VEC_GEN_ZERO_PAD_EN
        // Zero-padded top edge: every pixel yields a vector.
        i_rdy = 1'b1;
        i_vld = 1'b1;
        i_data = 8'h00; tick();
        chk("pad_v00", 32'(o_vld), 32'd1);
        chk("pad_d00", 32'(o_data), 32'(vec(8'h00, 8'h00, 8'h00)));
        i_data = 8'h01; tick();
        chk("pad_v01", 32'(o_vld), 32'd1);
        chk("pad_d01", 32'(o_data), 32'(vec(8'h00, 8'h00, 8'h01)));
        i_data = 8'h02; tick();
        chk("pad_d02", 32'(o_data), 32'(vec(8'h00, 8'h00, 8'h02)));
        i_data = 8'h03; tick();
        chk("pad_d03", 32'(o_data), 32'(vec(8'h00, 8'h00, 8'h03)));
        i_data = 8'h10; tick();
        chk("pad_d10", 32'(o_data), 32'(vec(8'h00, 8'h00, 8'h10)));
        i_data = 8'h11; tick();
        chk("pad_v11", 32'(o_vld), 32'd1);
        chk("pad_d11", 32'(o_data), 32'(vec(8'h00, 8'h01, 8'h11)));
        i_data = 8'h12; i_eof = 1'b1; tick();
        chk("pad_d12", 32'(o_data), 32'(vec(8'h00, 8'h02, 8'h12)));
        chk("pad_eof", 32'(o_eof), 32'd1);
        i_data = 8'h00; i_eof = 1'b0; tick();
        chk("pad_nf_d", 32'(o_data), 32'(vec(8'h00, 8'h00, 8'h00)));
        chk("pad_nf_e", 32'(o_eof), 32'd0);
        i_vld = 1'b0; tick();
        chk("pad_idle", 32'(o_vld), 32'd0);
`else
        // Frame A: three rows streamed back to back.
        i_rdy = 1'b1;
        i_vld = 1'b1;
        for (int n = 0; n < 12; n++) begin
            i_data = 8'((n / 4) * 16 + (n % 4));
            tick();
            chk("a_vld", 32'(o_vld), 32'(n >= 8));
            if (n >= 8) begin
                chk("a_data", 32'(o_data),
                    32'(vec(8'(n % 4), 8'(16 + n % 4), 8'(32 + n % 4))));
            end
        end

        // Downstream stall while the 0x23 vector is pending.
        i_rdy  = 1'b0;
        i_data = 8'h30;
        #1;
        chk("bp_rdy0", 32'(o_rdy), 32'd0);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("bp_vld",  32'(o_vld),  32'd1);
            chk("bp_data", 32'(o_data), 32'(vec(8'h03, 8'h13, 8'h23)));
            chk("bp_eof",  32'(o_eof),  32'd0);
            chk("bp_rdy",  32'(o_rdy),  32'd0);
        end
        i_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            i_data = 8'(8'h30 + c);
            i_eof  = (c == 3);
            tick();
            chk("a4_vld",  32'(o_vld),  32'd1);
            chk("a4_data", 32'(o_data), 32'(vec(8'(8'h10 + c), 8'(8'h20 + c), 8'(8'h30 + c))));
            chk("a4_eof",  32'(o_eof),  32'(c == 3));
        end

        // Frame B: two priming rows give nothing, then an early eof in STREAM.
        i_eof = 1'b0;
        for (int n = 0; n < 8; n++) begin
            i_data = 8'((n / 4) * 16 + (n % 4));
            tick();
            chk("b_prime", 32'(o_vld), 32'd0);
        end
        i_data = 8'h20; tick();
        chk("b_vld20",  32'(o_vld),  32'd1);
        chk("b_data20", 32'(o_data), 32'(vec(8'h00, 8'h10, 8'h20)));
        chk("b_eof20",  32'(o_eof),  32'd0);
        i_data = 8'h21; i_eof = 1'b1; tick();
        chk("b_data21", 32'(o_data), 32'(vec(8'h01, 8'h11, 8'h21)));
        chk("b_eof21",  32'(o_eof),  32'd1);

        // Frame C: eof on 0x12 while still priming yields no output.
        for (int n = 0; n < 7; n++) begin
            i_data = 8'((n / 4) * 16 + (n % 4));
            i_eof  = (n == 6);
            tick();
            chk("c_prime", 32'(o_vld), 32'd0);
        end
        i_eof = 1'b0;
        i_vld = 1'b0;
        tick();
        chk("c_idle", 32'(o_vld), 32'd0);

        // Frame D: distinct data proves the frame restarted at col 0, row 0.
        i_vld = 1'b1;
        for (int n = 0; n < 8; n++) begin
            i_data = 8'(8'h80 + (n / 4) * 16 + (n % 4));
            tick();
            chk("d_prime", 32'(o_vld), 32'd0);
        end
        i_data = 8'hA0; tick();
        chk("d_vld",  32'(o_vld),  32'd1);
        chk("d_data", 32'(o_data), 32'(vec(8'h80, 8'h90, 8'hA0)));
        i_vld = 1'b0; tick();
        chk("d_drop", 32'(o_vld), 32'd0);
        i_vld = 1'b1; i_data = 8'hA1; tick();
        chk("d_vld1",  32'(o_vld),  32'd1);
        chk("d_data1", 32'(o_data), 32'(vec(8'h81, 8'h91, 8'hA1)));

        // Mid-frame reset discards the pending vector and the partial frame.
        i_vld = 1'b0;
        i_rdy = 1'b0;
        i_rst = 1'b1;
        tick();
        chk("mr_vld",  32'(o_vld),  32'd0);
        chk("mr_data", 32'(o_data), 32'd0);
        i_rst = 1'b0;
        i_rdy = 1'b1;
        i_vld = 1'b1;
        for (int n = 0; n < 8; n++) begin
            i_data = 8'((n / 4) * 16 + (n % 4));
            tick();
            chk("e_prime", 32'(o_vld), 32'd0);
        end
        i_data = 8'h20; tick();
        chk("e_vld",  32'(o_vld),  32'd1);
        chk("e_data", 32'(o_data), 32'(vec(8'h00, 8'h10, 8'h20)));
        i_vld = 1'b0; tick();
        chk("e_idle", 32'(o_vld), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/col_vec_gen.md
COL_VEC_GEN -- requirements
Module: col_vec_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter KERNEL_H, default 7, column-vector height in rows (valid range 2..15).
REQ-003 SHALL have parameter IMG_W, default 64, image width in pixels (valid range 2..4096).
REQ-004 SHALL have port i_clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_vld  input  1  upstream raster pixel valid.
REQ-007 SHALL have port i_eof  input  1  upstream end-of-frame, qualified by i_vld.
REQ-008 SHALL have port i_data  input  DATA_W  raster pixel, row-major, left to right.
REQ-009 SHALL have port o_rdy  output  1  ready to accept a pixel from upstream.
REQ-010 SHALL have port i_rdy  input  1  downstream column PE is ready.
REQ-011 SHALL have port o_vld  output  1  o_data/o_eof valid.
REQ-012 SHALL have port o_eof  output  1  marks the final vector of a frame.
REQ-013 SHALL have port o_data  output  [KERNEL_H-1:0][DATA_W-1:0]  column vector; element 0 = oldest (top) row, element KERNEL_H-1 = current pixel.

Function
REQ-014 SHALL store KERNEL_H-1 previous rows in line buffers of IMG_W entries each, addressed by column counter col (0..IMG_W-1).
REQ-015 SHALL accept a pixel when i_vld && o_rdy; o_rdy SHALL equal !o_vld || i_rdy.
REQ-016 On accept at column col: o_data[KERNEL_H-1] = i_data; o_data[k] = line buffer k at col for k < KERNEL_H-1; line buffers at col SHALL shift one row older, with i_data written as the newest.
REQ-017 Output latency SHALL be exactly 1 cycle: o_vld rises the cycle after an accept that produces a vector.
REQ-018 While o_vld && !i_rdy, o_vld, o_data and o_eof SHALL hold stable and no input SHALL be accepted.
REQ-019 o_vld SHALL clear the cycle after a transfer (o_vld && i_rdy) with no new producing accept.
REQ-020 col SHALL increment per accept and wrap IMG_W-1 -> 0; on wrap, row counter SHALL increment, saturating at KERNEL_H-1.
REQ-021 FSM states SHALL be PRIME (row < KERNEL_H-1) and STREAM (row == KERNEL_H-1). PRIME -> STREAM on col wrap when row == KERNEL_H-2. Any -> PRIME on accepted i_eof.
REQ-022 In PRIME, accepted pixels SHALL update the line buffers without producing a vector.
REQ-023 In STREAM, every accepted pixel SHALL produce one vector.
REQ-024 Accepted i_eof SHALL clear col and row the next cycle, regardless of position. If a vector is produced, o_eof=1 on that vector. An eof accepted in PRIME SHALL produce no output.
REQ-025 Back-to-back transfers SHALL sustain 1 pixel per cycle when i_vld and i_rdy are held high.

Reset
REQ-026 On i_rst: o_vld=0, o_eof=0, o_data=0, col=0, row=0, state=PRIME; o_rdy=1 the cycle after reset.
REQ-027 Line buffer contents SHALL NOT be reset; no output may depend on stale contents.
REQ-028 Reset mid-frame SHALL discard any pending vector and partial frame.

Configuration
REQ-029 Macro COL_VEC_GEN_ZERO_PAD_EN SHALL select top-edge handling.
REQ-030 With COL_VEC_GEN_ZERO_PAD_EN defined, every accepted pixel SHALL produce a vector, including in PRIME. Elements k < KERNEL_H-1-row SHALL be forced to 0. An eof accepted in PRIME SHALL emit o_eof.
REQ-031 Without COL_VEC_GEN_ZERO_PAD_EN, behaviour SHALL follow REQ-022 and REQ-024.

Verification (KERNEL_H=3, IMG_W=4, pixel = row*16+col, i_rdy=1 unless stated)
REQ-032 Reset: assert i_rst 2 cycles -> o_vld=0, o_eof=0, o_data=0; o_rdy=1 next cycle.
REQ-033 Stream 12 pixels continuously -> no o_vld for the first 8; pixel 0x20 -> o_data={[0]=0x00,[1]=0x10,[2]=0x20} one cycle later; then 0x21,0x22,0x23 vectors on consecutive cycles.
REQ-034 Drop i_rdy for 5 cycles while o_vld=1 -> o_data/o_eof stable, o_rdy=0, i_data not consumed; resume -> no vector lost or duplicated.
REQ-035 Send i_eof with pixel 0x33 (4 rows) -> final vector {0x13,0x23,0x33} with o_eof=1; the next frame's first 8 pixels produce no output.
REQ-036 Send i_eof with pixel 0x12 (PRIME) -> no o_vld. Next frame pixel 0x00 starts at col=0, row=0.
REQ-037 With COL_VEC_GEN_ZERO_PAD_EN: pixel 0x01 -> o_data={0x00,0x00,0x01}, o_vld=1. Pixel 0x11 -> {0x00,0x01,0x11}.
